io_bus_controller: RTL and testbench
====================================

// Module: io_bus_controller
// PURPOSE
//  Memory-mapped front end for the board IO block (HEX/LEDR/LEDG/switch/key registers).
//  Arbitrates round-robin between CPU and debug requesters and decodes addresses into the IO
//  block's one-hot write strobes and switch/key read select. Sequences each access through a
//  3-state FSM and returns read data plus ack/err. Keeps shadow copies of write-only registers.
// PARAMETERS
//  DATA_BIT_WIDTH  32           data bus width; io_out/io_data_in width
//  ADDR_BIT_WIDTH  32           requester address width
//  IO_BASE         32'hF0000000 base address; offsets: HEX 0x00, LEDR 0x04, LEDG 0x08, KEYS 0x10, SW 0x14
// PORTS
//  clk            in   1    clock
//  reset          in   1    synchronous, active-high reset
//  cpu_req        in   1    CPU request; held until cpu_ack
//  cpu_we         in   1    1=write, 0=read
//  cpu_addr       in   ADDR CPU byte address
//  cpu_wdata      in   DATA CPU write data
//  cpu_ack        out  1    1-cycle completion pulse to CPU
//  dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_ack   same as cpu_*, debug requester
//  rsp_err        out  1    valid with either ack: unmapped addr or write to read-only
//  rsp_rdata      out  DATA valid with either ack; 0 on writes and on err
//  is_hex/is_ledr/is_ledg out 1  one-hot write strobes to IO block
//  is_switches    out  1    read select to IO block (1=switches, 0=keys)
//  io_data_in     out  DATA write data to IO block
//  io_out         in   DATA IO block read data (combinational from its registered inputs)
// BEHAVIOUR
//  States: IDLE -> ACCESS -> RESP -> IDLE. Reset: state=IDLE, all outputs 0, shadows 0,
//   last_grant=DBG (CPU wins first tie).
//  IDLE: is_switches=0 (io_out shows keys). If any req: grant per arbiter, latch we/addr/wdata
//   of winner, record winner in last_grant, -> ACCESS. Requests sampled only in IDLE.
//  Arbitration: one requester -> it wins; both -> the one not in last_grant.
//  ACCESS (1 cycle): io_data_in=latched wdata. Write to HEX/LEDR/LEDG: its strobe high this
//   cycle only, update shadow (HEX: full word; LEDR: [9:0]; LEDG: [7:0]; rest 0).
//   Read SW: is_switches=1, capture {22'b0,io_out[9:0]}. Read KEYS: is_switches=0, capture keys.
//   Read HEX/LEDR/LEDG: return shadow. Write to KEYS/SW or unmapped offset: no strobe, err=1.
//   Read unmapped: rdata=0, err=1. Address match requires addr[ADDR-1:5]==IO_BASE[ADDR-1:5] and
//   addr[1:0]==0; otherwise unmapped.
//  RESP (1 cycle): winner's ack=1, rsp_err/rsp_rdata driven; loser's ack stays 0; -> IDLE.
//   Latency: req high at edge k -> ack high in cycle k+2. Back-to-back: next grant at edge k+3.
//  Requester dropping req before ack: access still completes, ack still pulses.
//  Reset mid-operation: abort immediately, no ack, no further strobe, return to IDLE.
//  Strobes are mutually exclusive and never high outside ACCESS.
// CONFIGURATION
//  KEY_EDGE_LATCH_EN defined: 4-bit sticky press register; keys sampled from io_out[3:0] every
//   IDLE cycle; bit sets on 1->0 transition (active-low keys). KEYS read returns {28'b0,sticky}
//   and clears it in ACCESS; a press detected the same cycle as the clear stays set. Reset clears.
//  Not defined: KEYS read returns raw {28'b0,io_out[3:0]}; no sticky register.
// STRUCTURE
//  Package io_bus_pkg: offset constants, state enum (IDLE/ACCESS/RESP), requester id enum.
//  Sub-module io_rr_arbiter: 2-requester round-robin, inputs req[1:0]/last_grant, grant out.
// TESTING
//  1 CPU write 0x0000_0305 to 0xF0000004 -> is_ledr high exactly 1 cycle, io_data_in=0x305,
//    cpu_ack 2 cycles after req, err=0; read back 0xF0000004 -> rdata=0x305.
//  2 Switches=10'h2A5, CPU read 0xF0000014 -> is_switches=1 in ACCESS, rdata=0x2A5, err=0.
//  3 CPU and dbg req same cycle after reset -> CPU acked first, dbg acked 3 cycles later.
//  4 Write 0xF0000010 -> no strobe, err=1; read 0xF0000100 -> rdata=0, err=1.
//  5 Reset asserted in ACCESS of an LEDG write -> no ack, strobe drops, state IDLE next cycle.
//  6 KEY_EDGE_LATCH_EN: key0 1->0->1 then read KEYS -> rdata=0x1; second read -> 0x0.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared constants and types for the board IO bus front end:
// register offsets, access FSM states and requester ids.
package io_bus_pkg;

  localparam logic [4:0] OFF_HEX  = 5'h00;
  localparam logic [4:0] OFF_LEDR = 5'h04;
  localparam logic [4:0] OFF_LEDG = 5'h08;
  localparam logic [4:0] OFF_KEYS = 5'h10;
  localparam logic [4:0] OFF_SW   = 5'h14;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

endpackage

// File: rtl/io_bus_controller_if.sv
// Requester, response and IO-block signals of the IO bus front end.
// master = requesters + IO block model, slave = the controller.
interface io_bus_controller_if #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int ADDR_BIT_WIDTH = 32
) ();

  logic                      cpu_req;
  logic                      cpu_we;
  logic [ADDR_BIT_WIDTH-1:0] cpu_addr;
  logic [DATA_BIT_WIDTH-1:0] cpu_wdata;
  logic                      cpu_ack;

  logic                      dbg_req;
  logic                      dbg_we;
  logic [ADDR_BIT_WIDTH-1:0] dbg_addr;
  logic [DATA_BIT_WIDTH-1:0] dbg_wdata;
  logic                      dbg_ack;

  logic                      rsp_err;
  logic [DATA_BIT_WIDTH-1:0] rsp_rdata;

  logic                      is_hex;
  logic                      is_ledr;
  logic                      is_ledg;
  logic                      is_switches;
  logic [DATA_BIT_WIDTH-1:0] io_data_in;
  logic [DATA_BIT_WIDTH-1:0] io_out;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output io_out,
    input  cpu_ack, dbg_ack, rsp_err, rsp_rdata,
    input  is_hex, is_ledr, is_ledg, is_switches, io_data_in
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  io_out,
    output cpu_ack, dbg_ack, rsp_err, rsp_rdata,
    output is_hex, is_ledr, is_ledg, is_switches, io_data_in
  );

endinterface

// File: rtl/io_rr_arbiter.sv
// Two-requester round-robin arbiter (CPU / debug).
// On a tie the requester that did not win last time is granted.
module io_rr_arbiter
  import io_bus_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    lastGrant,
  output req_id_t    grant
);

  // lone requester wins; a tie alternates away from the last winner
  always_comb begin
    grant = REQ_CPU;
    unique case (1'b1)
      (req == 2'b11): grant = (lastGrant == REQ_CPU) ? REQ_DBG : REQ_CPU;
      (req == 2'b10): grant = REQ_DBG;
      default:        grant = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/io_bus_controller.sv
// Memory-mapped front end for the board IO block (HEX/LEDR/LEDG/keys/switches).
// Optional KEY_EDGE_LATCH_EN: sticky key-press register cleared by a KEYS read.
module io_bus_controller
  import io_bus_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int ADDR_BIT_WIDTH = 32,
  parameter logic [ADDR_BIT_WIDTH-1:0] IO_BASE = 32'hF0000000
) (
  input logic                clk,
  input logic                reset,
  io_bus_controller_if.slave bus
);

  state_t  state, stateNext;
  req_id_t lastGrant, grant;

  logic                      latWe;
  logic [ADDR_BIT_WIDTH-1:0] latAddr;
  logic [DATA_BIT_WIDTH-1:0] latWdata;
  logic [DATA_BIT_WIDTH-1:0] shadowHex;
  logic [9:0]                shadowLedr;
  logic [7:0]                shadowLedg;
  logic                      rspErr;
  logic [DATA_BIT_WIDTH-1:0] rspRdata;

  logic                      accErr;
  logic [DATA_BIT_WIDTH-1:0] accRdata;
  logic                      hexStb, ledrStb, ledgStb, swSel;
  logic [3:0]                keysVal;
  logic                      anyReq, baseHit, inResp;
  logic                      hitHex, hitLedr, hitLedg, hitKeys, hitSw;
  logic                      unusedBits;

  assign anyReq  = bus.cpu_req | bus.dbg_req;
  assign baseHit = (latAddr[ADDR_BIT_WIDTH-1:5] == IO_BASE[ADDR_BIT_WIDTH-1:5])
                 && (latAddr[1:0] == 2'b00);
  assign hitHex  = baseHit && (latAddr[4:0] == OFF_HEX);
  assign hitLedr = baseHit && (latAddr[4:0] == OFF_LEDR);
  assign hitLedg = baseHit && (latAddr[4:0] == OFF_LEDG);
  assign hitKeys = baseHit && (latAddr[4:0] == OFF_KEYS);
  assign hitSw   = baseHit && (latAddr[4:0] == OFF_SW);
  assign inResp  = (state == RESP) && !reset;
  assign unusedBits = ^bus.io_out[DATA_BIT_WIDTH-1:10];

  io_rr_arbiter u_arb (
    .req       ({bus.dbg_req, bus.cpu_req}),
    .lastGrant (lastGrant),
    .grant     (grant)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // IDLE -> ACCESS -> RESP -> IDLE, one cycle each after a grant
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // address decode and read mux for the access cycle
  always_comb begin
    hexStb   = 1'b0;
    ledrStb  = 1'b0;
    ledgStb  = 1'b0;
    swSel    = 1'b0;
    accErr   = 1'b0;
    accRdata = '0;
    if (state == ACCESS) begin
      if (latWe) begin
        unique case (1'b1)
          hitHex:  hexStb  = 1'b1;
          hitLedr: ledrStb = 1'b1;
          hitLedg: ledgStb = 1'b1;
          default: accErr  = 1'b1;
        endcase
      end else begin
        unique case (1'b1)
          hitSw: begin
            swSel    = 1'b1;
            accRdata = DATA_BIT_WIDTH'(bus.io_out[9:0]);
          end
          hitKeys: accRdata = DATA_BIT_WIDTH'(keysVal);
          hitHex:  accRdata = shadowHex;
          hitLedr: accRdata = DATA_BIT_WIDTH'(shadowLedr);
          hitLedg: accRdata = DATA_BIT_WIDTH'(shadowLedg);
          default: accErr   = 1'b1;
        endcase
      end
    end
  end

  // grant latch, shadow registers and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant  <= REQ_DBG;
      latWe      <= 1'b0;
      latAddr    <= '0;
      latWdata   <= '0;
      shadowHex  <= '0;
      shadowLedr <= '0;
      shadowLedg <= '0;
      rspErr     <= 1'b0;
      rspRdata   <= '0;
    end else begin
      if (state == IDLE && anyReq) begin
        lastGrant <= grant;
        latWe     <= (grant == REQ_CPU) ? bus.cpu_we    : bus.dbg_we;
        latAddr   <= (grant == REQ_CPU) ? bus.cpu_addr  : bus.dbg_addr;
        latWdata  <= (grant == REQ_CPU) ? bus.cpu_wdata : bus.dbg_wdata;
      end
      if (hexStb)  shadowHex  <= latWdata;
      if (ledrStb) shadowLedr <= latWdata[9:0];
      if (ledgStb) shadowLedg <= latWdata[7:0];
      if (state == ACCESS) begin
        rspErr   <= accErr;
        rspRdata <= accRdata;
      end
    end
  end

`ifdef KEY_EDGE_LATCH_EN
  logic [3:0] keyPrev, keySticky, keyPress;
  logic       keyClr;

  assign keyPress = (state == IDLE) ? (keyPrev & ~bus.io_out[3:0]) : 4'b0;
  assign keyClr   = (state == ACCESS) && !latWe && hitKeys;
  assign keysVal  = keySticky;

  // keys are active-low: a 1->0 step seen in IDLE is a press
  always_ff @(posedge clk) begin
    if (reset) begin
      keyPrev   <= 4'b0;
      keySticky <= 4'b0;
    end else begin
      if (state == IDLE) keyPrev <= bus.io_out[3:0];
      keySticky <= (keyClr ? 4'b0 : keySticky) | keyPress;
    end
  end
`else
  assign keysVal = bus.io_out[3:0];
`endif

  assign bus.is_hex      = hexStb  && !reset;
  assign bus.is_ledr     = ledrStb && !reset;
  assign bus.is_ledg     = ledgStb && !reset;
  assign bus.is_switches = swSel   && !reset;
  assign bus.io_data_in  = (state == ACCESS && !reset) ? latWdata : '0;
  assign bus.cpu_ack     = inResp && (lastGrant == REQ_CPU);
  assign bus.dbg_ack     = inResp && (lastGrant == REQ_DBG);
  assign bus.rsp_err     = inResp && rspErr;
  assign bus.rsp_rdata   = inResp ? rspRdata : '0;

endmodule

// File: tb/tb_io_bus_controller.sv
// Self-checking bench for io_bus_controller: directed cases plus
// random CPU/debug traffic against a register-level reference model.
module tb_io_bus_controller;

  localparam logic [31:0] BASE = 32'hF0000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] sw = 10'h0;
  logic [3:0] keys = 4'hF;

  int checks = 0;
  int passes = 0;
  int fails = 0;

  int hexN = 0, ledrN = 0, ledgN = 0, swN = 0, multiN = 0;
  logic [31:0] lastIoData = 32'h0;

  logic [31:0] mHex = 0, mLedr = 0, mLedg = 0;
  logic [3:0]  stickyM = 0;
  bit          lastWasDbg = 1'b1;

  io_bus_controller_if #(.DATA_BIT_WIDTH(32), .ADDR_BIT_WIDTH(32)) bus ();

  io_bus_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.io_out = bus.is_switches ? {22'h2AAAAA, sw} : {28'h0, keys};

  always @(negedge clk) begin
    if (bus.is_hex) hexN++;
    if (bus.is_ledr) ledrN++;
    if (bus.is_ledg) ledgN++;
    if (bus.is_switches) swN++;
    if (int'(bus.is_hex) + int'(bus.is_ledr) + int'(bus.is_ledg) > 1) multiN++;
    if (bus.is_hex | bus.is_ledr | bus.is_ledg) lastIoData = bus.io_data_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // register-level model: 0 none, 1 hex, 2 ledr, 3 ledg, 4 switch select
  function automatic void refAccess(input bit we, input logic [31:0] addr,
                                    input logic [31:0] wdata, output logic [31:0] rd,
                                    output bit err, output int stb);
    logic [31:0] off;
    rd = 0; err = 0; stb = 0;
    off = addr - BASE;
    if (addr < BASE || off >= 32 || addr % 4 != 0) begin
      err = 1;
      return;
    end
    if (we) begin
      case (off)
        0: begin stb = 1; mHex = wdata; end
        4: begin stb = 2; mLedr = wdata % 1024; end
        8: begin stb = 3; mLedg = wdata % 256; end
        default: err = 1;
      endcase
    end else begin
      case (off)
        0:  rd = mHex;
        4:  rd = mLedr;
        8:  rd = mLedg;
        20: begin rd = {22'h0, sw}; stb = 4; end
        16: begin
`ifdef KEY_EDGE_LATCH_EN
          rd = {28'h0, stickyM};
          stickyM = 0;
`else
          rd = {28'h0, keys};
`endif
        end
        default: err = 1;
      endcase
    end
  endfunction

  function automatic logic [15:0] stbVec(input int s);
    return {4'(s == 1), 4'(s == 2), 4'(s == 3), 4'(s == 4)};
  endfunction

  function automatic logic [15:0] stbSeen(input int h0, l0, g0, s0);
    return {4'(hexN - h0), 4'(ledrN - l0), 4'(ledgN - g0), 4'(swN - s0)};
  endfunction

  task automatic issue(input bit who, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    if (who) begin
      bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata; bus.dbg_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    end
  endtask

  task automatic waitAcks(input bit wantC, input bit wantD,
                          output int cAt, output int dAt,
                          output logic [31:0] cRd, output logic [31:0] dRd,
                          output bit cErr, output bit dErr, output int spurious);
    int cyc;
    bit cDone, dDone;
    cAt = -1; dAt = -1; cRd = 0; dRd = 0; cErr = 0; dErr = 0; spurious = 0;
    cDone = !wantC; dDone = !wantD; cyc = 0;
    while (!(cDone && dDone) && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (bus.cpu_ack) begin
        if (!cDone) begin
          cAt = cyc; cRd = bus.rsp_rdata; cErr = bus.rsp_err; cDone = 1; bus.cpu_req = 1'b0;
        end else spurious++;
      end
      if (bus.dbg_ack) begin
        if (!dDone) begin
          dAt = cyc; dRd = bus.rsp_rdata; dErr = bus.rsp_err; dDone = 1; bus.dbg_req = 1'b0;
        end else spurious++;
      end
    end
  endtask

  task automatic single(input bit who, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag,
                        output logic [31:0] rd, output bit err);
    logic [31:0] eRd, cRd, dRd;
    bit eErr, cErr, dErr;
    int eStb, cAt, dAt, sp, h0, l0, g0, s0;
    refAccess(we, addr, wdata, eRd, eErr, eStb);
    lastWasDbg = who;
    h0 = hexN; l0 = ledrN; g0 = ledgN; s0 = swN;
    issue(who, we, addr, wdata);
    waitAcks(!who, who, cAt, dAt, cRd, dRd, cErr, dErr, sp);
    rd  = who ? dRd : cRd;
    err = who ? dErr : cErr;
    check({tag, " latency"}, who ? dAt : cAt, 2);
    check({tag, " rdata"}, rd, eRd);
    check({tag, " err"}, 32'(err), 32'(eErr));
    check({tag, " strobes"}, 32'(stbSeen(h0, l0, g0, s0)), 32'(stbVec(eStb)));
    check({tag, " spurious ack"}, sp, 0);
    if (eStb >= 1 && eStb <= 3) check({tag, " io_data_in"}, lastIoData, wdata);
    @(posedge clk); #1;
  endtask

  task automatic pair(input bit cWe, input logic [31:0] cAd, input logic [31:0] cWd,
                      input bit dWe, input logic [31:0] dAd, input logic [31:0] dWd,
                      input string tag);
    logic [31:0] cE, dE, cRd, dRd;
    bit cEE, dEE, cEr, dEr, dbgFirst;
    int cS, dS, cAt, dAt, sp, h0, l0, g0, s0;
    dbgFirst = !lastWasDbg;
    if (dbgFirst) begin
      refAccess(dWe, dAd, dWd, dE, dEE, dS);
      refAccess(cWe, cAd, cWd, cE, cEE, cS);
      lastWasDbg = 1'b0;
    end else begin
      refAccess(cWe, cAd, cWd, cE, cEE, cS);
      refAccess(dWe, dAd, dWd, dE, dEE, dS);
      lastWasDbg = 1'b1;
    end
    h0 = hexN; l0 = ledrN; g0 = ledgN; s0 = swN;
    issue(1'b0, cWe, cAd, cWd);
    issue(1'b1, dWe, dAd, dWd);
    waitAcks(1'b1, 1'b1, cAt, dAt, cRd, dRd, cEr, dEr, sp);
    check({tag, " cpu latency"}, cAt, dbgFirst ? 5 : 2);
    check({tag, " dbg latency"}, dAt, dbgFirst ? 2 : 5);
    check({tag, " cpu rdata"}, cRd, cE);
    check({tag, " dbg rdata"}, dRd, dE);
    check({tag, " errs"}, {cEr, dEr}, {cEE, dEE});
    check({tag, " strobes"}, 32'(stbSeen(h0, l0, g0, s0)), 32'(stbVec(cS) + stbVec(dS)));
    check({tag, " spurious ack"}, sp, 0);
    @(posedge clk); #1;
  endtask

  task automatic setKeys(input logic [3:0] v);
    stickyM = stickyM | (keys & ~v);
    keys = v;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pickAddr();
    logic [31:0] offs [5] = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h14};
    int r;
    r = $urandom_range(0, 9);
    if (r <= 4) return BASE + offs[r];
    if (r == 5) return BASE + 32'($urandom_range(0, 31));
    if (r == 6) return BASE + 32'h100;
    if (r == 7) return $urandom;
    if (r == 8) return BASE + 32'h4;
    return BASE + 32'h14;
  endfunction

  initial begin
    logic [31:0] rd;
    bit err;
    int acks;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset ctrl outputs",
          {bus.cpu_ack, bus.dbg_ack, bus.rsp_err, bus.is_hex,
           bus.is_ledr, bus.is_ledg, bus.is_switches}, 0);
    check("reset rsp_rdata", bus.rsp_rdata, 0);
    check("reset io_data_in", bus.io_data_in, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // simultaneous requests after reset: CPU first, debug 3 cycles later
    pair(1'b0, BASE + 32'h0, 32'h0, 1'b0, BASE + 32'h8, 32'h0, "tie after reset");

    // LEDR write, then read back
    single(1'b0, 1'b1, BASE + 32'h4, 32'h0000_0305, "ledr write", rd, err);
    check("ledr write err", 32'(err), 0);
    check("ledr io_data_in", lastIoData, 32'h305);
    single(1'b0, 1'b0, BASE + 32'h4, 32'h0, "ledr read", rd, err);
    check("ledr readback", rd, 32'h305);

    // switches read, upper io_out bits must be masked
    sw = 10'h2A5;
    single(1'b0, 1'b0, BASE + 32'h14, 32'h0, "sw read", rd, err);
    check("sw value", rd, 32'h2A5);
    check("sw err", 32'(err), 0);

    // writes to read-only and unmapped reads
    single(1'b0, 1'b1, BASE + 32'h10, 32'hDEAD, "keys write", rd, err);
    check("keys write err", 32'(err), 1);
    single(1'b1, 1'b0, BASE + 32'h100, 32'h0, "unmapped read", rd, err);
    check("unmapped rdata", rd, 0);
    check("unmapped err", 32'(err), 1);
    single(1'b0, 1'b0, BASE + 32'h6, 32'h0, "misaligned read", rd, err);
    check("misaligned err", 32'(err), 1);

    // key press latching (raw key view when the latch is not built)
    setKeys(4'hE);
    setKeys(4'hF);
    single(1'b0, 1'b0, BASE + 32'h10, 32'h0, "keys read 1", rd, err);
`ifdef KEY_EDGE_LATCH_EN
    check("sticky key0", rd, 32'h1);
`else
    check("raw keys", rd, 32'hF);
`endif
    single(1'b1, 1'b0, BASE + 32'h10, 32'h0, "keys read 2", rd, err);
`ifdef KEY_EDGE_LATCH_EN
    check("sticky cleared", rd, 32'h0);
`else
    check("raw keys again", rd, 32'hF);
`endif

    // reset during the access cycle of an LEDG write
    issue(1'b0, 1'b1, BASE + 32'h8, 32'hA5);
    @(posedge clk); #1;
    check("ledg strobe in access", 32'(bus.is_ledg), 1);
    reset = 1'b1;
    #1;
    check("ledg strobe on reset", 32'(bus.is_ledg), 0);
    check("no ack on reset", 32'(bus.cpu_ack), 0);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    reset = 1'b0;
    check("post reset outputs",
          {bus.cpu_ack, bus.dbg_ack, bus.is_hex, bus.is_ledr,
           bus.is_ledg, bus.io_data_in}, 0);
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      acks += int'(bus.cpu_ack) + int'(bus.dbg_ack);
    end
    check("aborted access no ack", acks, 0);
    mHex = 0; mLedr = 0; mLedg = 0; stickyM = 0; lastWasDbg = 1'b1;
    single(1'b0, 1'b0, BASE + 32'h8, 32'h0, "ledg after reset", rd, err);
    check("ledg cleared", rd, 0);

    // random traffic against the model
    for (int i = 0; i < 40; i++) begin
      int mode;
      sw = 10'($urandom);
      if ($urandom_range(0, 3) == 0) setKeys(4'($urandom));
      mode = $urandom_range(0, 3);
      if (mode < 2)
        single(mode[0], 1'($urandom), pickAddr(), $urandom,
               $sformatf("rnd%0d single", i), rd, err);
      else
        pair(1'($urandom), pickAddr(), $urandom, 1'($urandom), pickAddr(), $urandom,
             $sformatf("rnd%0d pair", i));
    end

    check("strobes exclusive", multiN, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
